bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using iterative double-dabble, one input bit per clock. It replaces the combinational 9-bit converter in display paths where timing or area matters. It adds a valid/ready handshake, generic width and digit count, an optional signed mode, and an overflow flag. It sits between datapath counters/ALU results and the seven-segment digit mux.

Parameters:
BIN_W, 9, binary input width (2..32)
DIGITS, 3, number of BCD output digits (1..10); need not cover full input range, see out_ovf
SIGNED, 0, 0 = unsigned input; 1 = two's-complement input, magnitude converted, sign reported on out_neg

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept a word this cycle
in_bin  in  BIN_W  binary value, sampled on in_valid&&in_ready
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  downstream accepts result
out_bcd  out  4*DIGITS  packed BCD, digit 0 = bits [3:0] (units)
out_neg  out  1  input was negative (SIGNED=1 only; tied 0 otherwise)
out_ovf  out  1  value exceeded 10^DIGITS-1; out_bcd then holds the low DIGITS digits

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, out_valid=0, out_bcd=0, out_neg=0, out_ovf=0, bit counter=0, shift register=0. in_ready reads 1 once rst_n is high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, load shift reg with magnitude (SIGNED=1 and MSB set: two's-complement negate, BIN_W-bit unsigned result, so -2^(BIN_W-1) converts correctly). Latch sign into out_neg. Clear BCD accumulator, ovf and counter. Go to SHIFT.
- SHIFT, one iteration per cycle, exactly BIN_W cycles:
  - Every digit >=5 gets +3 (all digits in parallel, from pre-shift values).
  - Then {bcd, shift} shifts left by 1.
  - If bit 4*DIGITS-1 of the corrected accumulator is 1 before the shift, out_ovf sets. It is sticky for this conversion.
  - Counter increments. When it reaches BIN_W-1, go to DONE.
  - in_ready=0 throughout.
- DONE: out_valid=1. out_bcd/out_neg/out_ovf are stable registered values.
  - On out_ready: out_valid drops next cycle and state goes to IDLE.
  - in_ready = out_ready in DONE. If in_valid&&out_ready together, the result is consumed and the new word is loaded into SHIFT in the same edge (no IDLE bubble).
- Latency: accept edge at cycle 0 -> out_valid high after BIN_W+1 edges. Throughput is one word per BIN_W+1 cycles with out_ready tied 1.
- out_bcd updates only on the DONE entry edge. It is never visible mid-conversion. It holds its last value in IDLE.
- in_bin is ignored outside the accept cycle. Changes during SHIFT have no effect.
- out_ready while out_valid=0 is ignored.
- rst_n asserted mid-SHIFT or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- Counter width is $clog2(BIN_W). Accumulator is 4*DIGITS bits. No width truncation warnings are allowed.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE/SHIFT/DONE)
  - localparam function min_digits(width) = ceil(width*log10 2), used by instantiators to size DIGITS
  - BCD digit width constant (4)
- Sub-module bcd_digit_adj: combinational 4-bit "add 3 if >=5". Generated DIGITS times inside bin_to_bcd_seq.
- Shared by the existing combinational converter's successors.

Test Plan:
1. BIN_W=9, DIGITS=3, in_bin=511, out_ready=1 -> out_bcd=12'h511, ovf=0, out_valid rises exactly 10 edges after accept, pulse 1 cycle.
2. Exhaustive 0..511 back-to-back with in_valid held high and out_ready=1 -> every result matches the reference model; new word accepted on each DONE cycle, no dropped or duplicated words.
3. BIN_W=8, DIGITS=2, in_bin=100 -> out_bcd=8'h00, ovf=1. Then in_bin=99 -> 8'h99, ovf=0 (ovf not carried over).
4. Backpressure: out_ready low for 7 cycles in DONE -> out_valid, out_bcd stay constant, in_ready=0. Release -> accepted, next word loads the same edge.
5. BIN_W=8, SIGNED=1, in_bin=8'h80 -> out_neg=1, out_bcd=12'h128. in_bin=8'hFF -> neg=1, 12'h001. in_bin=8'h7F -> neg=0, 12'h127.
6. Assert rst_n low for one cycle at SHIFT iteration 4 of a conversion -> all outputs return to 0 asynchronously, no out_valid. The next conversion of 42 gives 12'h042.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter family.
package bcd_pkg;

  // Width of one packed BCD digit.
  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Digits needed to show every value of a width-bit unsigned number:
  // ceil(width * log10(2)), with log10(2) approximated as 0.30103.
  function automatic int unsigned min_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  // Pre-shift correction so the following doubling carries into the next digit.
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes on both sides, optional signed input and an
// overflow flag when the value does not fit in DIGITS digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        in_bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*DIGITS-1:0] out_bcd,
  output logic                    out_neg,
  output logic                    out_ovf
);

  localparam int unsigned ACC_W = BCD_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_sh;
  logic [BIN_W-1:0]   shreg;
  logic [BIN_W-1:0]   mag;
  logic [CNT_W-1:0]   cnt;
  logic               neg_r;
  logic               ovf_r;
  logic               in_neg;
  logic               carry;
  logic               last;
  logic               accept;

  // Per-digit +3 correction on the pre-shift accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[g*BCD_W +: BCD_W]),
      .dout (acc_adj[g*BCD_W +: BCD_W])
    );
  end

  // Magnitude of the input, shifted accumulator and iteration bookkeeping.
  always_comb begin
    in_neg = SIGNED && in_bin[BIN_W-1];
    mag    = in_neg ? (~in_bin) + 1'b1 : in_bin;
    carry  = acc_adj[ACC_W-1];
    acc_sh = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
    last   = (cnt == CNT_W'(BIN_W - 1));
  end

  // Handshake and next-state decode; DONE can hand off straight to SHIFT.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid && in_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Conversion datapath; outputs are only written on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      shreg   <= '0;
      cnt     <= '0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      acc   <= '0;
      shreg <= mag;
      cnt   <= '0;
      neg_r <= in_neg;
      ovf_r <= 1'b0;
    end else if (state == SHIFT) begin
      acc   <= acc_sh;
      shreg <= {shreg[BIN_W-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
      ovf_r <= ovf_r | carry;
      if (last) begin
        out_bcd <= acc_sh;
        out_neg <= neg_r;
        out_ovf <= ovf_r | carry;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: three configurations, expected results
// computed arithmetically and queued at accept, checked by a separate monitor.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  iv  = '0;
  logic [2:0]  orr = 3'b111;
  logic [2:0]  ir, ov, neg, ovf;
  logic [8:0]  ib0 = '0;
  logic [7:0]  ib1 = '0;
  logic [7:0]  ib2 = '0;
  logic [11:0] bcd0, bcd2;
  logic [7:0]  bcd1;

  int checks = 0;
  int errors = 0;

  // Entries are {neg, ovf, bcd[11:0]}
  logic [13:0] q0[$];
  logic [13:0] q1[$];
  logic [13:0] q2[$];

  bin_to_bcd_seq #(.BIN_W(9), .DIGITS(3), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_bin(ib0),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_bcd(bcd0), .out_neg(neg[0]), .out_ovf(ovf[0]));

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_bin(ib1),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_bcd(bcd1), .out_neg(neg[1]), .out_ovf(ovf[1]));

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_bin(ib2),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_bcd(bcd2), .out_neg(neg[2]), .out_ovf(ovf[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  // Plain decimal arithmetic: magnitude, overflow, then low digits by /10.
  function automatic logic [13:0] ref_model(input longint v, input int unsigned w,
                                            input int unsigned digits, input bit sgn);
    longint      mag;
    longint      lim;
    logic        n;
    logic        o;
    logic [11:0] b;
    b   = '0;
    n   = sgn && (v >= (64'sd1 << (w - 1)));
    mag = n ? ((64'sd1 << w) - v) : v;
    lim = 1;
    for (int unsigned i = 0; i < digits; i++) lim = lim * 10;
    o   = (mag >= lim);
    mag = mag % lim;
    for (int unsigned i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {n, o, b};
  endfunction

  // Presents one word on DUT d; returns the number of refused negedges before accept.
  task automatic send(input int d, input logic [31:0] v, output int n);
    case (d)
      0:       ib0 = v[8:0];
      1:       ib1 = v[7:0];
      default: ib2 = v[7:0];
    endcase
    iv[d] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ir[d]) break;
      n++;
      if (n > 60) begin
        timeout($sformatf("accept_dut%0d", d));
        iv[d] = 1'b0;
        return;
      end
    end
    case (d)
      0:       q0.push_back(ref_model(longint'(v[8:0]), 9, 3, 1'b0));
      1:       q1.push_back(ref_model(longint'(v[7:0]), 8, 2, 1'b0));
      default: q2.push_back(ref_model(longint'(v[7:0]), 8, 3, 1'b1));
    endcase
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      @(posedge clk); #1;
      k++;
      if (k > 200) begin
        timeout("drain");
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: a result is consumed on the edge after a negedge showing valid&&ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov[0] && orr[0]) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_unexpected: got %h required no output", bcd0);
        end else check("dut0_result", {50'd0, neg[0], ovf[0], bcd0}, {50'd0, q0.pop_front()});
      end
      if (ov[1] && orr[1]) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected: got %h required no output", bcd1);
        end else check("dut1_result", {50'd0, neg[1], ovf[1], 4'h0, bcd1}, {50'd0, q1.pop_front()});
      end
      if (ov[2] && orr[2]) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut2_unexpected: got %h required no output", bcd2);
        end else check("dut2_result", {50'd0, neg[2], ovf[2], bcd2}, {50'd0, q2.pop_front()});
      end
    end
  end

  initial begin
    int          n;
    int          k;
    logic [11:0] held;

    // Reset state
    #12;
    check("rst_out_valid", 64'(ov), 64'(3'b000));
    check("rst_bcd0", 64'(bcd0), 64'(12'h000));
    check("rst_flags", 64'({neg, ovf}), 64'(6'b0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(ir), 64'(3'b111));

    // 511: out_valid after the accept edge plus BIN_W shift edges, one-cycle pulse
    send(0, 511, n);
    k = 0;
    while (!ov[0] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ov[0]) timeout("latency_511");
    else check("latency_edges_after_accept", 64'(k), 64'd9);
    @(posedge clk); #1;
    check("valid_pulse_width", 64'(ov[0]), 64'd0);
    check("bcd_held_idle", 64'(bcd0), 64'(12'h511));
    drain();

    // Exhaustive back-to-back, one accept every BIN_W+1 cycles
    for (int v = 0; v < 512; v++) begin
      send(0, 32'(v), n);
      if (v > 0 && n != 9) check("b2b_spacing", 64'(n), 64'd9);
      else if (v > 0) checks++;
    end
    drain();

    // Overflow on two digits, not carried into the next word
    send(1, 100, n);
    drain();
    check("ovf_100_bcd", 64'(bcd1), 64'(8'h00));
    check("ovf_100_flag", 64'(ovf[1]), 64'd1);
    send(1, 99, n);
    drain();
    check("ovf_99_bcd", 64'(bcd1), 64'(8'h99));
    check("ovf_99_flag", 64'(ovf[1]), 64'd0);
    for (int i = 0; i < 25; i++) send(1, $urandom_range(0, 255), n);
    drain();

    // Signed corner cases and random signed words
    send(2, 32'h80, n);
    send(2, 32'hFF, n);
    send(2, 32'h7F, n);
    send(2, 32'h00, n);
    for (int i = 0; i < 25; i++) send(2, $urandom_range(0, 255), n);
    drain();

    // Backpressure: hold DONE for 7 cycles with a new word waiting
    orr[0] = 1'b0;
    send(0, 32'($urandom_range(0, 511)), n);
    k = 0;
    while (!ov[0] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ov[0]) timeout("bp_done");
    held = bcd0;
    ib0 = 9'd123;
    iv[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(ov[0]), 64'd1);
      check("bp_bcd_held", 64'(bcd0), 64'(held));
      check("bp_in_ready_low", 64'(ir[0]), 64'd0);
      @(posedge clk); #1;
    end
    orr[0] = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(ir[0]), 64'd1);
    q0.push_back(ref_model(123, 9, 3, 1'b0));
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("bp_handoff_valid", 64'(ov[0]), 64'd0);
    check("bp_handoff_shift", 64'(ir[0]), 64'd0);
    drain();

    // Reset in the middle of a conversion
    send(0, 300, n);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(ov[0]), 64'd0);
    check("midrst_bcd", 64'(bcd0), 64'(12'h000));
    check("midrst_flags", 64'({neg[0], ovf[0]}), 64'd0);
    q0.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    k = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov[0]) k++;
    end
    check("midrst_no_valid", 64'(k), 64'd0);
    @(posedge clk); #1;
    send(0, 42, n);
    drain();
    check("after_rst_42", 64'(bcd0), 64'(12'h042));

    check("queues_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
